// File: rtl/wb_stream_writer_ctrl.sv
// Wishbone read-master sequencer: fetches a buffer from memory in FIFO-gated bursts.
// Optional macro WB_STREAM_WRITER_CTRL_BURST_EN selects incrementing-burst CTI tagging.
module wb_stream_writer_ctrl #(
  parameter int unsigned WB_AW   = 32,
  parameter int unsigned WB_DW   = 32,
  parameter int unsigned FIFO_AW = 6
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic                 enable,
  input  logic [WB_AW-1:0]     start_adr,
  input  logic [WB_AW-1:0]     buf_size,
  input  logic [WB_AW-1:0]     burst_size,
  output logic [WB_AW-1:0]     wbm_adr_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  output logic [WB_DW-1:0]     fifo_d_o,
  output logic                 fifo_wr_o,
  input  logic [FIFO_AW:0]     fifo_cnt_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam logic [WB_AW-1:0] Depth  = WB_AW'(2 ** FIFO_AW);
  localparam logic [WB_AW-1:0] AdrInc = WB_AW'(WB_DW / 8);
  localparam logic [WB_AW-1:0] One    = WB_AW'(1);

  typedef enum logic [1:0] {StIdle, StWait, StBurst, StFin} state_e;

  state_e           state_q, state_d;
  logic [WB_AW-1:0] adr_q, adr_d;
  logic [WB_AW-1:0] rem_q, rem_d;
  logic [WB_AW-1:0] blen_q, blen_d;
  logic [WB_AW-1:0] beat_q, beat_d;
  logic             cyc_q, cyc_d;
  logic             err_q, err_d;

  logic [WB_AW-1:0] len;
  logic [WB_AW-1:0] space;
  logic             ack_ev;
  logic             err_ev;

  assign len    = (blen_q < rem_q) ? blen_q : rem_q;
  assign space  = Depth - WB_AW'(fifo_cnt_i);
  // An error beat wins over a simultaneous ack.
  assign err_ev = cyc_q & wbm_err_i;
  assign ack_ev = cyc_q & wbm_ack_i & ~wbm_err_i;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    blen_d  = blen_q;
    beat_d  = beat_q;
    cyc_d   = cyc_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (enable) begin
          adr_d   = start_adr;
          rem_d   = buf_size;
          blen_d  = (burst_size == '0) ? One : burst_size;
          err_d   = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (rem_q == '0) begin
          state_d = StFin;
        end else if (space >= len) begin
          beat_d  = len;
          cyc_d   = 1'b1;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (err_ev) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = StFin;
        end else if (ack_ev) begin
          adr_d  = adr_q + AdrInc;
          rem_d  = rem_q - One;
          beat_d = beat_q - One;
          if (beat_q == One) begin
            cyc_d   = 1'b0;
            state_d = (rem_q == One) ? StFin : StWait;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= StIdle;
      adr_q   <= '0;
      rem_q   <= '0;
      blen_q  <= '0;
      beat_q  <= '0;
      cyc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      blen_q  <= blen_d;
      beat_q  <= beat_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
    end
  end

  assign wbm_adr_o = adr_q;
  assign wbm_sel_o = '1;
  assign wbm_we_o  = 1'b0;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_bte_o = 2'b00;

`ifdef WB_STREAM_WRITER_CTRL_BURST_EN
  assign wbm_cti_o = !cyc_q          ? 3'b000 :
                     (beat_q == One) ? 3'b111 : 3'b010;
`else
  assign wbm_cti_o = 3'b000;
`endif

  assign fifo_wr_o = ack_ev;
  assign fifo_d_o  = wbm_dat_i;

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StFin);
  assign err_o  = err_q;

endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
// Self-checking bench for wb_stream_writer_ctrl: vector table, hand sequences, random transfers
// compared against a transfer-level reference model.
module tb_wb_stream_writer_ctrl;

  localparam int unsigned FifoAw = 3;
  localparam int unsigned Depth  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] start_adr, buf_size, burst_size;
  logic [31:0] wbm_adr, wbm_dat, fifo_d;
  logic [3:0]  wbm_sel;
  logic        wbm_we, wbm_cyc, wbm_stb, wbm_ack, wbm_err;
  logic [2:0]  wbm_cti;
  logic [1:0]  wbm_bte;
  logic        fifo_wr, busy, done, err;
  logic [FifoAw:0] fifo_cnt, fifo_lvl, hold_val;
  logic        hold;
  logic        pop;

  // Stimulus knobs set by the test sequence and read by the slave/monitor
  logic [31:0] errb, salt;
  logic        wait_en;

  // Monitor records
  logic [31:0] q_adr[$];
  logic [31:0] q_dat[$];
  logic [2:0]  q_cti[$];
  int          slv_beat, mon_bursts, mon_done, mon_ovf;
  logic        cyc_prev;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  assign fifo_cnt = hold ? hold_val : fifo_lvl;

  wb_stream_writer_ctrl #(
    .WB_AW  (32),
    .WB_DW  (32),
    .FIFO_AW(FifoAw)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .enable    (enable),
    .start_adr (start_adr),
    .buf_size  (buf_size),
    .burst_size(burst_size),
    .wbm_adr_o (wbm_adr),
    .wbm_dat_i (wbm_dat),
    .wbm_sel_o (wbm_sel),
    .wbm_we_o  (wbm_we),
    .wbm_cyc_o (wbm_cyc),
    .wbm_stb_o (wbm_stb),
    .wbm_cti_o (wbm_cti),
    .wbm_bte_o (wbm_bte),
    .wbm_ack_i (wbm_ack),
    .wbm_err_i (wbm_err),
    .fifo_d_o  (fifo_d),
    .fifo_wr_o (fifo_wr),
    .fifo_cnt_i(fifo_cnt),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  function automatic logic [31:0] data_fn(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E37_79B1) ^ s;
  endfunction

  // Output FIFO occupancy with a random drain
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fifo_lvl <= '0;
    else        fifo_lvl <= fifo_lvl + (FifoAw + 1)'(fifo_wr) - (FifoAw + 1)'(pop);
  end

  // Slave drives on the falling edge, then samples the DUT 1 time unit later
  always @(negedge clk) begin
    if (wbm_cyc && wbm_stb) begin
      if (slv_beat + 1 == int'(errb)) begin
        wbm_err = 1'b1;
        wbm_ack = 1'($urandom_range(0, 1));
      end else begin
        wbm_err = 1'b0;
        wbm_ack = wait_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end else begin
      wbm_ack = 1'b0;
      wbm_err = 1'b0;
    end
    wbm_dat = data_fn(wbm_adr, salt);
    pop     = (fifo_lvl != 0) && ($urandom_range(0, 1) == 1);
    #1;
    if (enable && !busy) begin
      q_adr.delete();
      q_dat.delete();
      q_cti.delete();
      slv_beat   = 0;
      mon_bursts = 0;
      mon_done   = 0;
      mon_ovf    = 0;
    end
    if (fifo_wr) begin
      q_adr.push_back(wbm_adr);
      q_dat.push_back(fifo_d);
      if (!hold && fifo_lvl >= (FifoAw + 1)'(Depth)) mon_ovf++;
    end
    if (wbm_cyc && wbm_stb && wbm_ack && !wbm_err) begin
      q_cti.push_back(wbm_cti);
      slv_beat++;
    end
    if (wbm_cyc && !cyc_prev) mon_bursts++;
    cyc_prev = wbm_cyc;
    if (done) mon_done++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_cti(input int i, input int sz, input int b);
    bit last;
    last = ((i + 1) % b == 0) || (i + 1 == sz);
`ifdef WB_STREAM_WRITER_CTRL_BURST_EN
    return last ? 3'b111 : 3'b010;
`else
    return last ? 3'b000 : 3'b000;
`endif
  endfunction

  // Transfer-level model: words written, bursts issued, error outcome
  task automatic model(input int sz, input int bs, input int eb,
                       output int words, output int bursts, output bit e);
    int b, att;
    b      = (bs == 0) ? 1 : bs;
    e      = (eb != 0) && (eb <= sz);
    att    = e ? eb : sz;
    words  = e ? eb - 1 : sz;
    bursts = (att + b - 1) / b;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 3000 && mon_done == 0; i++) @(negedge clk);
    #2;
    chk({nm, ".finished"}, 32'(mon_done != 0), 32'd1);
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic check_result(input string nm, input logic [31:0] sa, input int sz, input int bs,
                              input int exp_w, input int exp_b, input bit exp_e);
    int bad_ad, bad_cti, b;
    logic [31:0] ea;
    b       = (bs == 0) ? 1 : bs;
    bad_ad  = 0;
    bad_cti = 0;
    chk({nm, ".done_cnt"}, 32'(mon_done), 32'd1);
    chk({nm, ".words"}, 32'(q_adr.size()), 32'(exp_w));
    chk({nm, ".bursts"}, 32'(mon_bursts), 32'(exp_b));
    chk({nm, ".err_o"}, 32'(err), 32'(exp_e));
    chk({nm, ".busy_end"}, 32'(busy), 32'd0);
    chk({nm, ".ovf"}, 32'(mon_ovf), 32'd0);
    for (int i = 0; i < q_adr.size() && i < exp_w; i++) begin
      ea = sa + 32'(4 * i);
      if (q_adr[i] !== ea || q_dat[i] !== data_fn(ea, salt)) bad_ad++;
    end
    chk({nm, ".adr_dat"}, 32'(bad_ad), 32'd0);
    chk({nm, ".cti_beats"}, 32'(q_cti.size()), 32'(exp_w));
    for (int i = 0; i < q_cti.size(); i++)
      if (q_cti[i] !== exp_cti(i, sz, b)) bad_cti++;
    chk({nm, ".cti"}, 32'(bad_cti), 32'd0);
  endtask

  task automatic run_xfer(input string nm, input logic [31:0] sa, input int sz, input int bs,
                          input int eb, input bit we, input int exp_w, input int exp_b,
                          input bit exp_e);
    @(negedge clk);
    start_adr  = sa;
    buf_size   = 32'(sz);
    burst_size = 32'(bs);
    errb       = 32'(eb);
    wait_en    = we;
    salt       = $urandom;
    enable     = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    #2;
    chk({nm, ".busy_start"}, 32'(busy), 32'd1);
    chk({nm, ".err_cleared"}, 32'(err), 32'd0);
    // A second enable while busy must be dropped
    @(negedge clk);
    start_adr = ~sa;
    enable    = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_done(nm);
    check_result(nm, sa, sz, bs, exp_w, exp_b, exp_e);
  endtask

  typedef struct {
    logic [31:0] sa;
    int          sz, bs, eb;
    bit          we;
    int          exp_w, exp_b;
    bit          exp_e;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int w, bu, d0;
    bit e;
    logic [31:0] sa;
    int sz, bs, eb;

    tbl[0] = '{32'h0000_1000, 8, 4, 0, 1'b0, 8, 2, 1'b0};
    tbl[1] = '{32'h0000_2000, 10, 4, 0, 1'b1, 10, 3, 1'b0};
    tbl[2] = '{32'h0000_3000, 0, 4, 0, 1'b0, 0, 0, 1'b0};
    tbl[3] = '{32'h0000_4000, 8, 4, 3, 1'b0, 2, 1, 1'b1};
    tbl[4] = '{32'hFFFF_FFF8, 4, 4, 0, 1'b0, 4, 1, 1'b0};
    tbl[5] = '{32'h0000_5004, 5, 0, 0, 1'b1, 5, 5, 1'b0};
    tbl[6] = '{32'h0000_6000, 7, 8, 0, 1'b1, 7, 1, 1'b0};
    tbl[7] = '{32'h0000_7000, 9, 3, 9, 1'b1, 8, 3, 1'b1};

    rst_n = 1'b0; enable = 1'b0; start_adr = '0; buf_size = '0; burst_size = '0;
    hold = 1'b0; hold_val = '0; errb = '0; wait_en = 1'b0; salt = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst.cyc", 32'(wbm_cyc), 32'd0);
    chk("rst.stb", 32'(wbm_stb), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.cti", 32'(wbm_cti), 32'd0);
    chk("rst.adr", wbm_adr, 32'd0);
    chk("rst.const", {24'd0, wbm_sel, 1'b0, wbm_we, wbm_bte}, {24'd0, 4'hF, 4'b0000});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_xfer($sformatf("tbl%0d", i), tbl[i].sa, tbl[i].sz, tbl[i].bs, tbl[i].eb, tbl[i].we,
               tbl[i].exp_w, tbl[i].exp_b, tbl[i].exp_e);

    // Zero-length transfer timing
    @(negedge clk);
    buf_size = '0; burst_size = 32'd4; errb = '0; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    #2;
    chk("len0.c1_busy", 32'(busy), 32'd1);
    chk("len0.c1_done", 32'(done), 32'd0);
    @(negedge clk);
    #2;
    chk("len0.c2_done", 32'(done), 32'd1);
    chk("len0.c2_busy", 32'(busy), 32'd1);
    chk("len0.c2_cyc", 32'(wbm_cyc), 32'd0);
    @(negedge clk);
    #2;
    chk("len0.c3_done", 32'(done), 32'd0);
    chk("len0.c3_busy", 32'(busy), 32'd0);
    chk("len0.bursts", 32'(mon_bursts), 32'd0);

    // FIFO space gating
    @(negedge clk);
    hold = 1'b1; hold_val = 4'd6;
    start_adr = 32'h0000_8000; buf_size = 32'd4; burst_size = 32'd4; errb = '0;
    wait_en = 1'b0; salt = $urandom; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    chk("space.stall_cyc", 32'(wbm_cyc), 32'd0);
    chk("space.stall_busy", 32'(busy), 32'd1);
    @(negedge clk);
    hold_val = 4'd4;
    @(negedge clk);
    #2;
    chk("space.issue_cyc", 32'(wbm_cyc), 32'd1);
    wait_done("space");
    check_result("space", 32'h0000_8000, 4, 4, 4, 1, 1'b0);
    hold = 1'b0;

    // Asynchronous reset in the middle of a burst
    @(negedge clk);
    start_adr = 32'hFFFF_FFF0; buf_size = 32'd16; burst_size = 32'd8; errb = '0;
    wait_en = 1'b1; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 100 && !(wbm_cyc && slv_beat >= 2); i++) @(negedge clk);
    #2;
    chk("arst.in_burst", 32'(wbm_cyc), 32'd1);
    d0 = mon_done;
    #1 rst_n = 1'b0;
    #1;
    chk("arst.cyc", 32'(wbm_cyc), 32'd0);
    chk("arst.stb", 32'(wbm_stb), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #2;
    chk("arst.no_done", 32'(mon_done), 32'(d0));
    @(negedge clk);
    rst_n = 1'b1;

    // Random transfers against the model
    for (int k = 0; k < 20; k++) begin
      sa = $urandom & 32'hFFFF_FFFC;
      sz = $urandom_range(0, 20);
      bs = $urandom_range(0, 8);
      eb = ($urandom_range(0, 3) == 0 && sz != 0) ? $urandom_range(1, sz + 2) : 0;
      model(sz, bs, eb, w, bu, e);
      run_xfer($sformatf("rnd%0d", k), sa, sz, bs, eb, 1'($urandom_range(0, 1)), w, bu, e);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
